reset_conditioner: RTL and testbench

RESET_CONDITIONER -- requirements
Module: reset_conditioner

---
 rtl/reset_pkg.sv | 29 ++
 rtl/sync_debounce.sv | 63 ++++++
 rtl/reset_conditioner.sv | 92 +++++++++
 tb/tb_reset_conditioner.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// ============================================================================
// Module : reset_pkg
// Brief  : Shared state encoding, default parameters and width helper for
//          the push-button reset conditioner.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reset_pkg;

  typedef enum logic [1:0] {
    ASSERTED = 2'd0,
    HOLD     = 2'd1,
    RUN      = 2'd2
  } rst_state_t;

  localparam int unsigned c_DEF_SYNC_STAGES     = 2;
  localparam int unsigned c_DEF_DEBOUNCE_CYCLES = 100000;
  localparam int unsigned c_DEF_HOLD_CYCLES     = 16;
  localparam int unsigned c_DEF_CLK_DIV         = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : reset_pkg

`default_nettype wire

// File: rtl/sync_debounce.sv
// ============================================================================
// Module : sync_debounce
// Brief  : Synchronises the raw push-button and accepts a new level only
//          after it has persisted for DEBOUNCE_CYCLES consecutive cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_debounce
  import reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = c_DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_stable_o
);

  localparam int unsigned DEB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] c_DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]   w_shift;
  logic                   btn_sync;
  logic                   btn_stable_q, btn_stable_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;

  assign w_shift  = {sync_q, btn_i};
  assign btn_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d       = w_shift[SYNC_STAGES-1:0];
    btn_stable_d = btn_stable_q;
    deb_cnt_d    = '0;
    if (btn_sync != btn_stable_q) begin
      if (deb_cnt_q == c_DEB_LAST) begin
        btn_stable_d = btn_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // A cleared chain reads as a held-down button, so reset looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      btn_stable_q <= 1'b0;
      deb_cnt_q    <= '0;
    end else begin
      sync_q       <= sync_d;
      btn_stable_q <= btn_stable_d;
      deb_cnt_q    <= deb_cnt_d;
    end
  end

  assign btn_stable_o = btn_stable_q;

endmodule : sync_debounce

`default_nettype wire

// File: rtl/reset_conditioner.sv
// ============================================================================
// Module : reset_conditioner
// Brief  : Turns a bouncy push-button into a registered SoC reset with a
//          post-release hold, plus a free-running clock-enable divider.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_conditioner
  import reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = c_DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = c_DEF_HOLD_CYCLES,
  parameter int unsigned CLK_DIV         = c_DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic soc_rst_n,
  output logic clk_en,
  output logic running
);

  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int unsigned DIV_W  = cnt_width(CLK_DIV);
  localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0]  c_DIV_LAST  = DIV_W'(CLK_DIV - 1);

  logic              btn_stable;
  rst_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              soc_rst_n_q, soc_rst_n_d;

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clk          (clk),
    .rst          (rst),
    .btn_i        (btn_n),
    .btn_stable_o (btn_stable)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    unique case (state_q)
      ASSERTED: begin
        if (btn_stable) state_d = HOLD;
      end
      HOLD: begin
        // A renewed press wins over an expiring hold count.
        if (!btn_stable) begin
          state_d = ASSERTED;
        end else if (hold_cnt_q == c_HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!btn_stable) state_d = ASSERTED;
      end
      default: state_d = ASSERTED;
    endcase
    soc_rst_n_d = (state_d == RUN);
    div_cnt_d   = (div_cnt_q == c_DIV_LAST) ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ASSERTED;
      hold_cnt_q  <= '0;
      div_cnt_q   <= '0;
      soc_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      div_cnt_q   <= div_cnt_d;
      soc_rst_n_q <= soc_rst_n_d;
    end
  end

  assign soc_rst_n = soc_rst_n_q;
  assign clk_en    = (div_cnt_q == c_DIV_LAST);
  assign running   = (state_q == RUN);

endmodule : reset_conditioner

`default_nettype wire

// File: tb/tb_reset_conditioner.sv
// ============================================================================
// Module : tb_reset_conditioner
// Brief  : Self-checking bench for reset_conditioner (short and long hold).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_conditioner;
  import reset_pkg::*;

  localparam int S  = 2;
  localparam int D  = 8;
  localparam int HA = 4;
  localparam int HB = 16;
  localparam int CD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_n = 1'b1;
  logic soc_a, en_a, run_a, soc_b, en_b, run_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reset_conditioner #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HA), .CLK_DIV(CD)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .soc_rst_n(soc_a), .clk_en(en_a), .running(run_a)
  );

  // Long-hold copy: the hold window outlasts a full debounce, so a press can land inside it.
  reset_conditioner #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HB), .CLK_DIV(CD)
  ) u_dut_h (
    .clk(clk), .rst(rst), .btn_n(btn_n),
    .soc_rst_n(soc_b), .clk_en(en_b), .running(run_b)
  );

  // Reference: button history queue, accepted level after D agreeing cycles,
  // and the SoC is out of reset once that level has been high for hold+1 edges.
  bit   m_hist[$];
  bit   m_sync;
  bit   m_stable;
  int   m_diff, m_high, m_edges;

  always @(posedge clk) begin
    if (rst) begin
      m_hist.delete();
      for (int i = 0; i < S; i++) m_hist.push_back(1'b0);
      m_stable = 1'b0;
      m_diff   = 0;
      m_high   = 0;
      m_edges  = 0;
    end else begin
      m_sync = m_hist[S-1];
      m_high = m_stable ? m_high + 1 : 0;
      if (m_sync != m_stable) begin
        m_diff++;
        if (m_diff == D) begin
          m_stable = m_sync;
          m_diff   = 0;
        end
      end else begin
        m_diff = 0;
      end
      m_hist.push_front(btn_n);
      void'(m_hist.pop_back());
      m_edges++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_soc(input logic level, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (soc_a === level) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({soc_a, en_a, run_a} !== 3'b000) begin
        failures++;
        $display("FAIL reset_outputs: got soc/en/run=%b required 000", {soc_a, en_a, run_a});
      end
    end
  endtask

  task automatic test_clean_release();
    int lat;
    rst = 1'b0;
    wait_soc(1'b1, lat);
    checks++;
    if (lat !== S + D + HA) begin
      failures++;
      $display("FAIL release_latency: got %0d required %0d", lat, S + D + HA);
    end
    checks++;
    if (run_a !== 1'b1) begin
      failures++;
      $display("FAIL running_at_release: got %b required 1", run_a);
    end
  endtask

  task automatic test_divider();
    logic exp_en;
    rst = 1'b1; btn_n = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      exp_en = ((n + 1) % CD) == 0;
      checks++;
      if (en_a !== exp_en || en_b !== exp_en) begin
        failures++;
        $display("FAIL divider_cycle%0d: got %b/%b required %b", n, en_a, en_b, exp_en);
      end
    end
  endtask

  task automatic test_glitch();
    btn_n = 1'b0;
    for (int i = 0; i < 5; i++) step();
    btn_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (soc_a !== 1'b1) begin
        failures++;
        $display("FAIL glitch_soc: got %b required 1", soc_a);
      end
    end
    checks++;
    if (u_dut.u_deb.deb_cnt_q !== 3'd0) begin
      failures++;
      $display("FAIL glitch_deb_cnt: got %0d required 0", u_dut.u_deb.deb_cnt_q);
    end
  endtask

  task automatic test_press_run();
    int lat;
    btn_n = 1'b0;
    wait_soc(1'b0, lat);
    checks++;
    if (lat !== S + D) begin
      failures++;
      $display("FAIL press_latency: got %0d required %0d", lat, S + D);
    end
    btn_n = 1'b1;
    wait_soc(1'b1, lat);
    checks++;
    if (lat !== S + D + HA) begin
      failures++;
      $display("FAIL repress_release_latency: got %0d required %0d", lat, S + D + HA);
    end
  endtask

  task automatic test_press_hold();
    bit saw_hold = 1'b0;
    btn_n = 1'b0;
    for (int i = 0; i < 30; i++) step();
    btn_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) btn_n = 1'b0;
      step();
      if (u_dut_h.state_q == HOLD) saw_hold = 1'b1;
      checks++;
      if (soc_b !== 1'b0) begin
        failures++;
        $display("FAIL hold_press_soc: got %b required 0 at step %0d", soc_b, i);
      end
    end
    checks++;
    if (saw_hold !== 1'b1) begin
      failures++;
      $display("FAIL hold_entered: got %b required 1", saw_hold);
    end
    checks++;
    if (u_dut_h.state_q !== ASSERTED || u_dut_h.hold_cnt_q !== 4'd0) begin
      failures++;
      $display("FAIL hold_abort: got state=%0d hold_cnt=%0d required 0/0",
               u_dut_h.state_q, u_dut_h.hold_cnt_q);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    bit hit = 1'b0;
    btn_n = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (u_dut.u_deb.deb_cnt_q == 3'd5) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_reset_reach_cnt5: got timeout required deb_cnt=5");
    end
    for (int pass = 0; pass < 2; pass++) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (u_dut.state_q !== ASSERTED || soc_a !== 1'b0 || en_a !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset%0d_state: got state=%0d soc=%b en=%b required 0/0/0",
                 pass, u_dut.state_q, soc_a, en_a);
      end
      wait_soc(1'b1, lat);
      checks++;
      if (lat !== S + D + HA) begin
        failures++;
        $display("FAIL mid_reset%0d_latency: got %0d required %0d", pass, lat, S + D + HA);
      end
    end
  endtask

  task automatic test_random();
    int  len;
    logic exp_a, exp_b, exp_en;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 1500; ) begin
      btn_n = 1'($urandom_range(0, 1));
      len   = int'($urandom_range(1, 40));
      for (int k = 0; k <= len; k++) begin
        if (k == len) begin
          if ($urandom_range(0, 19) != 0) break;
          rst = 1'b1;
        end
        step();
        rst = 1'b0;
        c++;
        exp_a  = (m_high >= HA + 1);
        exp_b  = (m_high >= HB + 1);
        exp_en = ((m_edges + 1) % CD) == 0;
        checks++;
        if ({soc_a, run_a, en_a, soc_b, run_b, en_b} !== {exp_a, exp_a, exp_en, exp_b, exp_b, exp_en}) begin
          failures++;
          $display("FAIL random_cycle%0d: got a=%b%b%b b=%b%b%b required a=%b%b%b b=%b%b%b", c,
                   soc_a, run_a, en_a, soc_b, run_b, en_b,
                   exp_a, exp_a, exp_en, exp_b, exp_b, exp_en);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_release();
    test_divider();
    test_glitch();
    test_press_run();
    test_press_hold();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reset_conditioner

`default_nettype wire
